// File: rtl/cpu_pkg.sv
// Shared core types: register-file geometry and opaque control field.
// Used by the decoder, register file and the operand-fetch stage.
package cpu_pkg;

  localparam int XLEN       = 8;
  localparam int NREGS      = 4;
  localparam int REG_ADDR_W = $clog2(NREGS);
  localparam int OPC_W      = 6;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [OPC_W-1:0]      opcode_t;
  typedef logic [XLEN-1:0]       word_t;

endpackage

// File: rtl/operand_bypass.sv
// One operand port: captures the write the register file misses during
// its read cycle and selects range-zero / forward / capture / RF data.
module operand_bypass
  import cpu_pkg::*;
#(
  parameter int BUS_WIDTH = XLEN,
  parameter int DEPTH     = NREGS,
  parameter int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [ADDR_W-1:0]    f_addr,
  input  logic                 wb_we,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [BUS_WIDTH-1:0] wb_data,
  input  logic [BUS_WIDTH-1:0] rf_data,
  output logic [BUS_WIDTH-1:0] op
);

  logic                 byp;
  logic [BUS_WIDTH-1:0] byp_data;
  logic [31:0]          addr_ext;
  logic                 out_range;
  logic                 fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp      <= 1'b0;
      byp_data <= '0;
    end else begin
      byp      <= wb_we & (wb_addr == rd_addr);
      byp_data <= wb_data;
    end
  end

  assign addr_ext  = 32'(f_addr);
  assign out_range = (addr_ext >= DEPTH);
  assign fwd       = wb_we & (wb_addr == f_addr);

  // Overlapping conditions: first match wins.
  always_comb begin
    op = rf_data;
    priority case (1'b1)
      out_range: op = '0;
      fwd:       op = wb_data;
      byp:       op = byp_data;
      default:   op = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: holds one decoded instruction, drives RF read
// addresses and presents fully forwarded operands one cycle later.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int BUS_WIDTH = XLEN,
  parameter int DEPTH     = NREGS,
  parameter int OP_W      = OPC_W,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_rs_a,
  input  logic [ADDR_W-1:0]    in_rs_b,
  input  logic [ADDR_W-1:0]    in_rd,
  input  logic [OP_W-1:0]      in_op,
  output logic [ADDR_W-1:0]    rf_rd_addr_a,
  output logic [ADDR_W-1:0]    rf_rd_addr_b,
  input  logic [BUS_WIDTH-1:0] rf_rd_data_a,
  input  logic [BUS_WIDTH-1:0] rf_rd_data_b,
  input  logic                 wb_we,
  input  logic [ADDR_W-1:0]    wb_addr,
  input  logic [BUS_WIDTH-1:0] wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_op_a,
  output logic [BUS_WIDTH-1:0] out_op_b,
  output logic [ADDR_W-1:0]    out_rd,
  output logic [OP_W-1:0]      out_op
);

  logic              f_valid;
  logic [ADDR_W-1:0] f_rs_a;
  logic [ADDR_W-1:0] f_rs_b;
  logic [ADDR_W-1:0] f_rd;
  logic [OP_W-1:0]   f_op;
  logic              accept;

  assign in_ready = rst_n & (~f_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid <= 1'b0;
      f_rs_a  <= '0;
      f_rs_b  <= '0;
      f_rd    <= '0;
      f_op    <= '0;
    end else if (accept) begin
      f_valid <= 1'b1;
      f_rs_a  <= in_rs_a;
      f_rs_b  <= in_rs_b;
      f_rd    <= in_rd;
      f_op    <= in_op;
    end else if (out_ready) begin
      f_valid <= 1'b0;
    end
  end

  // Held instructions re-read every cycle so RF data tracks writes.
  assign rf_rd_addr_a = accept ? in_rs_a : f_rs_a;
  assign rf_rd_addr_b = accept ? in_rs_b : f_rs_b;

  assign out_valid = f_valid;
  assign out_rd    = f_rd;
  assign out_op    = f_op;

  operand_bypass #(
    .BUS_WIDTH(BUS_WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_byp_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_addr(rf_rd_addr_a),
    .f_addr (f_rs_a),
    .wb_we  (wb_we),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .rf_data(rf_rd_data_a),
    .op     (out_op_a)
  );

  operand_bypass #(
    .BUS_WIDTH(BUS_WIDTH),
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_byp_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_addr(rf_rd_addr_b),
    .f_addr (f_rs_b),
    .wb_we  (wb_we),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .rf_data(rf_rd_data_b),
    .op     (out_op_b)
  );

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a 4-entry instance against a
// non-bypassing synchronous-read RF model, plus a 3-entry range check.
module tb_operand_fetch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_rs_a = '0, in_rs_b = '0, in_rd = '0;
  logic [5:0] in_op = '0;
  logic [1:0] rf_rd_addr_a, rf_rd_addr_b;
  logic [7:0] rf_a, rf_b;
  logic       wb_we = 1'b0;
  logic [1:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_op_a, out_op_b;
  logic [1:0] out_rd;
  logic [5:0] out_op;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs_a(in_rs_a), .in_rs_b(in_rs_b),
    .in_rd(in_rd), .in_op(in_op),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_a), .rf_rd_data_b(rf_b),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_rd(out_rd), .out_op(out_op)
  );

  logic       d3_in_valid = 1'b0;
  logic       d3_in_ready;
  logic [1:0] d3_rs_a = '0, d3_rs_b = '0;
  logic [1:0] d3_addr_a, d3_addr_b;
  logic       d3_wb_we = 1'b0;
  logic [1:0] d3_wb_addr = '0;
  logic [7:0] d3_wb_data = '0;
  logic       d3_out_valid;
  logic [7:0] d3_op_a, d3_op_b;
  logic [1:0] d3_out_rd;
  logic [5:0] d3_out_op;

  operand_fetch #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d3_in_valid), .in_ready(d3_in_ready),
    .in_rs_a(d3_rs_a), .in_rs_b(d3_rs_b),
    .in_rd(2'd1), .in_op(6'd0),
    .rf_rd_addr_a(d3_addr_a), .rf_rd_addr_b(d3_addr_b),
    .rf_rd_data_a(8'hAB), .rf_rd_data_b(8'hAB),
    .wb_we(d3_wb_we), .wb_addr(d3_wb_addr), .wb_data(d3_wb_data),
    .out_valid(d3_out_valid), .out_ready(1'b1),
    .out_op_a(d3_op_a), .out_op_b(d3_op_b),
    .out_rd(d3_out_rd), .out_op(d3_out_op)
  );

  // RF model: registered read of the old contents, no write bypass.
  logic [7:0] mem [4] = '{default: 8'h00};
  always @(posedge clk) begin
    rf_a <= mem[rf_rd_addr_a];
    rf_b <= mem[rf_rd_addr_b];
    if (wb_we) mem[wb_addr] <= wb_data;
  end

  // Transfer log: {rd, op_a, op_b}.
  logic [17:0] xq [$];
  always @(posedge clk)
    if (rst_n && out_valid && out_ready)
      xq.push_back({out_rd, out_op_a, out_op_b});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic wb(input logic [1:0] a, input logic [7:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  logic [1:0] b_rs_a [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] b_rs_b [4] = '{2'd1, 2'd3, 2'd3, 2'd2};
  logic [7:0] b_ex_a [4] = '{8'h77, 8'h99, 8'h5A, 8'h00};
  logic [7:0] b_ex_b [4] = '{8'h77, 8'h5A, 8'h5A, 8'h99};
  int base;
  logic [17:0] e;

  initial begin
    // Reset: requests are ignored and the RF address is parked at 0.
    in_valid = 1'b1; in_rs_a = 2'd3; in_rs_b = 2'd2;
    #2;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_rf_addr_a", 32'(rf_rd_addr_a), 0);
    tick(); tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 32'(out_valid), 0);

    // Basic read.
    wb(2'd1, 8'h11);
    wb(2'd2, 8'h22);
    in_valid = 1'b1; in_rs_a = 2'd1; in_rs_b = 2'd2;
    in_rd = 2'd0; in_op = 6'd5;
    settle();
    chk("basic_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    settle();
    chk("basic_valid", 32'(out_valid), 1);
    chk("basic_op_a", 32'(out_op_a), 'h11);
    chk("basic_op_b", 32'(out_op_b), 'h22);
    chk("basic_op", 32'(out_op), 5);
    tick();
    settle();
    chk("basic_drain", 32'(out_valid), 0);

    // Write during the read cycle.
    in_valid = 1'b1; in_rs_a = 2'd3; in_rs_b = 2'd0; in_rd = 2'd1;
    wb_we = 1'b1; wb_addr = 2'd3; wb_data = 8'h5A;
    tick();
    in_valid = 1'b0; wb_we = 1'b0;
    settle();
    chk("rdcyc_rf_old", 32'(rf_a), 0);
    chk("rdcyc_op_a", 32'(out_op_a), 'h5A);
    chk("rdcyc_op_b", 32'(out_op_b), 0);
    tick();

    // Stall with a write in stall cycle 2.
    base = xq.size();
    in_valid = 1'b1; in_rs_a = 2'd1; in_rs_b = 2'd1; in_rd = 2'd1;
    tick();
    out_ready = 1'b0;
    in_rs_a = 2'd2; in_rs_b = 2'd2; in_rd = 2'd2;
    settle();
    chk("stall1_valid", 32'(out_valid), 1);
    chk("stall1_ready", 32'(in_ready), 0);
    chk("stall1_op_a", 32'(out_op_a), 'h11);
    tick();
    wb_we = 1'b1; wb_addr = 2'd1; wb_data = 8'h77;
    settle();
    chk("stall2_op_a", 32'(out_op_a), 'h77);
    chk("stall2_ready", 32'(in_ready), 0);
    chk("stall2_rd", 32'(out_rd), 1);
    tick();
    wb_we = 1'b0;
    settle();
    chk("stall3_op_a", 32'(out_op_a), 'h77);
    chk("stall3_op_b", 32'(out_op_b), 'h77);
    chk("stall3_ready", 32'(in_ready), 0);
    tick();
    out_ready = 1'b1;
    settle();
    chk("stall4_ready", 32'(in_ready), 1);
    chk("stall4_op_a", 32'(out_op_a), 'h77);
    tick();
    in_valid = 1'b0;
    settle();
    chk("reload_valid", 32'(out_valid), 1);
    chk("reload_rd", 32'(out_rd), 2);
    chk("reload_op_a", 32'(out_op_a), 'h22);
    tick();
    chk("stall_xfers", 32'(xq.size() - base), 2);
    e = xq[base];
    chk("stall_xfer0_rd", 32'(e[17:16]), 1);
    chk("stall_xfer0_a", 32'(e[15:8]), 'h77);

    // Same-cycle forward in the handshake cycle.
    in_valid = 1'b1; in_rs_a = 2'd0; in_rs_b = 2'd2;
    in_rd = 2'd3; in_op = 6'd9;
    tick();
    in_valid = 1'b0;
    wb_we = 1'b1; wb_addr = 2'd2; wb_data = 8'h99;
    settle();
    chk("fwd_rf_old", 32'(rf_b), 'h22);
    chk("fwd_op_b", 32'(out_op_b), 'h99);
    tick();
    wb_we = 1'b0;
    e = xq[xq.size() - 1];
    chk("fwd_xfer_b", 32'(e[7:0]), 'h99);
    chk("fwd_xfer_rd", 32'(e[17:16]), 3);

    // Back-to-back, out_ready held high.
    base = xq.size();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_rs_a = b_rs_a[i]; in_rs_b = b_rs_b[i]; in_rd = 2'(i);
      settle();
      chk("b2b_in_ready", 32'(in_ready), 1);
      if (i > 0) chk("b2b_valid", 32'(out_valid), 1);
      tick();
    end
    in_valid = 1'b0;
    settle();
    chk("b2b_last_valid", 32'(out_valid), 1);
    tick();
    settle();
    chk("b2b_drain", 32'(out_valid), 0);
    chk("b2b_xfers", 32'(xq.size() - base), 4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < xq.size()) begin
        e = xq[base + i];
        chk("b2b_rd", 32'(e[17:16]), 32'(i));
        chk("b2b_op_a", 32'(e[15:8]), 32'(b_ex_a[i]));
        chk("b2b_op_b", 32'(e[7:0]), 32'(b_ex_b[i]));
      end
    end

    // Reset while an operand is being presented.
    in_valid = 1'b1; in_rs_a = 2'd1; in_rs_b = 2'd1; in_rd = 2'd2;
    tick();
    in_rs_a = 2'd3;
    settle();
    chk("mid_valid_pre", 32'(out_valid), 1);
    base = xq.size();
    rst_n = 1'b0;
    #1;
    chk("mid_valid_async", 32'(out_valid), 0);
    chk("mid_in_ready", 32'(in_ready), 0);
    chk("mid_rf_addr", 32'(rf_rd_addr_a), 0);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    settle();
    chk("mid_no_emit", 32'(xq.size() - base), 0);
    chk("mid_valid_post", 32'(out_valid), 0);

    // Out-of-range register on a 3-entry file.
    d3_in_valid = 1'b1; d3_rs_a = 2'd3; d3_rs_b = 2'd2;
    tick();
    d3_in_valid = 1'b0;
    d3_wb_we = 1'b1; d3_wb_addr = 2'd3; d3_wb_data = 8'h44;
    settle();
    chk("d3_valid", 32'(d3_out_valid), 1);
    chk("d3_op_a_zero", 32'(d3_op_a), 0);
    chk("d3_op_b", 32'(d3_op_b), 'hAB);
    tick();
    d3_wb_we = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
